// File: rtl/tx_flow_ctrl.sv
// Credit-gated transmit scheduler: pops TX FIFO characters while credit lasts and gives queued FCTs priority.
// One registered token stage, refilled in the acceptance cycle so tokens flow with no bubbles.
module tx_flow_ctrl #(
  parameter int G_DATA_WIDTH_BITS = 8,
  parameter int G_ADDR_WIDTH_BITS = 6,
  parameter int G_CREDIT_MAX      = 56
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         link_up,
  input  logic [G_ADDR_WIDTH_BITS:0]   fill_level,
  input  logic [G_DATA_WIDTH_BITS-1:0] r_data,
  output logic                         r_en,
  input  logic                         fct_rcvd,
  input  logic                         fct_send_req,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         tx_ctrl,
  output logic [G_DATA_WIDTH_BITS-1:0] tx_data,
  output logic [5:0]                   credit,
  output logic                         credit_err
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    IDLE     = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam logic [6:0] CREDIT_MAX = 7'(G_CREDIT_MAX);

  state_t                         state_q, state_d;
  logic                           tx_valid_q, tx_valid_d;
  logic                           tx_ctrl_q, tx_ctrl_d;
  logic [G_DATA_WIDTH_BITS-1:0]   tx_data_q, tx_data_d;
  logic [5:0]                     credit_q, credit_d;
  logic [2:0]                     fct_pend_q, fct_pend_d;
  logic                           credit_err_q, credit_err_d;

  logic                           slot_free;
  logic                           load_fct;
  logic                           load_data;
  logic [6:0]                     credit_sum;
  logic [3:0]                     pend_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DISABLED;
      tx_valid_q   <= 1'b0;
      tx_ctrl_q    <= 1'b0;
      tx_data_q    <= '0;
      credit_q     <= '0;
      fct_pend_q   <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_valid_q   <= tx_valid_d;
      tx_ctrl_q    <= tx_ctrl_d;
      tx_data_q    <= tx_data_d;
      credit_q     <= credit_d;
      fct_pend_q   <= fct_pend_d;
      credit_err_q <= credit_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_valid_d   = tx_valid_q;
    tx_ctrl_d    = tx_ctrl_q;
    tx_data_d    = tx_data_q;
    credit_d     = credit_q;
    fct_pend_d   = fct_pend_q;
    credit_err_d = credit_err_q;
    slot_free    = 1'b0;
    load_fct     = 1'b0;
    load_data    = 1'b0;
    credit_sum   = '0;
    pend_sum     = '0;

    if (!link_up) begin
      // A held data token is dropped here; it was already popped from the FIFO.
      state_d    = DISABLED;
      tx_valid_d = 1'b0;
      tx_ctrl_d  = 1'b0;
      tx_data_d  = '0;
      credit_d   = '0;
      fct_pend_d = '0;
    end else begin
      case (state_q)
        DISABLED: state_d = IDLE;
        IDLE, HOLD: begin
          slot_free = (state_q == IDLE) || tx_ready;
          load_fct  = slot_free && (fct_pend_q != 3'd0);
          load_data = slot_free && !load_fct && (fill_level != '0) && (credit_q != 6'd0);

          if (load_fct) begin
            state_d    = HOLD;
            tx_valid_d = 1'b1;
            tx_ctrl_d  = 1'b1;
            tx_data_d  = '0;
          end else if (load_data) begin
            state_d    = HOLD;
            tx_valid_d = 1'b1;
            tx_ctrl_d  = 1'b0;
            tx_data_d  = r_data;
          end else if (slot_free) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
          end

          pend_sum = {1'b0, fct_pend_q} + 4'(fct_send_req) - 4'(load_fct);
          if (pend_sum > 4'd7) begin
            fct_pend_d   = 3'd7;
            credit_err_d = 1'b1;
          end else begin
            fct_pend_d = pend_sum[2:0];
          end

          // load_data implies credit_q >= 1, so the subtraction cannot wrap.
          credit_sum = {1'b0, credit_q} + (fct_rcvd ? 7'd8 : 7'd0) - 7'(load_data);
          if (credit_sum > CREDIT_MAX) begin
            credit_d     = CREDIT_MAX[5:0];
            credit_err_d = 1'b1;
          end else begin
            credit_d = credit_sum[5:0];
          end
        end
        default: state_d = DISABLED;
      endcase
    end
  end

  assign r_en       = load_data;
  assign tx_valid   = tx_valid_q;
  assign tx_ctrl    = tx_ctrl_q;
  assign tx_data    = tx_data_q;
  assign credit     = credit_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_tx_flow_ctrl.sv
// Directed scenarios followed by random traffic, all checked against a token/credit reference model.
module tb_tx_flow_ctrl;

  logic       clk;
  logic       rst_n;
  logic       link_up;
  logic [6:0] fill_level;
  logic [7:0] r_data;
  logic       r_en;
  logic       fct_rcvd;
  logic       fct_send_req;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_ctrl;
  logic [7:0] tx_data;
  logic [5:0] credit;
  logic       credit_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: upstream FIFO contents, output token, credit and FCT backlog.
  logic [7:0] q[$];
  bit         m_en, m_valid, m_ctrl, m_err;
  logic [7:0] m_data;
  int         m_credit, m_pend;

  tx_flow_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .link_up      (link_up),
    .fill_level   (fill_level),
    .r_data       (r_data),
    .r_en         (r_en),
    .fct_rcvd     (fct_rcvd),
    .fct_send_req (fct_send_req),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_ctrl      (tx_ctrl),
    .tx_data      (tx_data),
    .credit       (credit),
    .credit_err   (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_valid = 0; m_ctrl = 0; m_data = 8'h00;
    m_err = 0; m_credit = 0; m_pend = 0;
  endtask

  // One clock: inputs applied while clk is low, r_en checked before the edge, registers after.
  task automatic step(input bit lu, input bit fr, input bit fs, input bit rdy);
    bit free, ldf, ldd;
    int c, p;
    link_up = lu; fct_rcvd = fr; fct_send_req = fs; tx_ready = rdy;
    fill_level = 7'(q.size());
    r_data = (q.size() > 0) ? q[0] : 8'h00;
    #1;
    free = !m_valid || rdy;
    ldf  = lu && m_en && free && (m_pend > 0);
    ldd  = lu && m_en && free && !ldf && (q.size() > 0) && (m_credit > 0);
    chk("r_en", r_en, ldd);
    @(posedge clk);
    if (!lu) begin
      m_en = 0; m_valid = 0; m_credit = 0; m_pend = 0;
    end else if (!m_en) begin
      m_en = 1;
    end else begin
      if (ldf) begin
        m_valid = 1; m_ctrl = 1; m_data = 8'h00;
      end else if (ldd) begin
        m_valid = 1; m_ctrl = 0; m_data = q.pop_front();
      end else if (free) begin
        m_valid = 0;
      end
      p = m_pend + int'(fs) - int'(ldf);
      if (p > 7) begin p = 7; m_err = 1; end
      m_pend = p;
      c = m_credit + 8 * int'(fr) - int'(ldd);
      if (c > 56) begin c = 56; m_err = 1; end
      m_credit = c;
    end
    #1;
    chk("tx_valid", tx_valid, m_valid);
    chk("credit", credit, m_credit);
    chk("credit_err", credit_err, m_err);
    if (m_valid) begin
      chk("tx_ctrl", tx_ctrl, m_ctrl);
      chk("tx_data", tx_data, m_data);
    end
    @(negedge clk);
  endtask

  task automatic bounce();
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; link_up = 0; fill_level = '0; r_data = '0;
    fct_rcvd = 0; fct_send_req = 0; tx_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_credit", credit, 0);
    chk("rst_credit_err", credit_err, 0);
    chk("rst_r_en", r_en, 0);
    chk("rst_tx_ctrl", tx_ctrl, 0);
    chk("rst_tx_data", tx_data, 0);
    rst_n = 1'b1;

    // No credit: nothing leaves even with data queued.
    q.push_back(8'hA1); q.push_back(8'hB2); q.push_back(8'hC3);
    repeat (6) step(1, 0, 0, 1);
    chk("nocred_valid", tx_valid, 0);

    // One grant drains A1,B2,C3 back to back.
    step(1, 1, 0, 1);
    chk("grant_credit", credit, 8);
    step(1, 0, 0, 1);
    chk("a1", tx_data, 8'hA1);
    step(1, 0, 0, 1);
    chk("b2", tx_data, 8'hB2);
    step(1, 0, 0, 1);
    chk("c3", tx_data, 8'hC3);
    chk("credit_5", credit, 5);
    repeat (2) step(1, 0, 0, 1);

    // Ten queued with eight credits: exactly eight go out.
    bounce();
    for (int i = 0; i < 10; i++) q.push_back(8'(8'h10 + i));
    step(1, 1, 0, 1);
    repeat (14) step(1, 0, 0, 1);
    chk("ten_credit0", credit, 0);
    chk("ten_valid0", tx_valid, 0);
    chk("ten_fill2", fill_level, 2);

    // FCT requested while a data token is held jumps ahead of the next character.
    bounce();
    q.delete();
    q.push_back(8'h51); q.push_back(8'h52); q.push_back(8'h53);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("hold_51", tx_data, 8'h51);
    step(1, 0, 0, 1);
    chk("fct_ctrl", tx_ctrl, 1);
    chk("fct_data", tx_data, 0);
    step(1, 0, 0, 1);
    chk("after_fct_ctrl", tx_ctrl, 0);
    chk("after_fct_data", tx_data, 8'h52);
    repeat (3) step(1, 0, 0, 1);

    // Eight grants from zero saturate at 56 and set the sticky error.
    bounce();
    q.delete();
    repeat (8) step(1, 1, 0, 1);
    repeat (2) step(1, 0, 0, 1);
    chk("sat_credit", credit, 56);
    chk("sat_err", credit_err, 1);
    bounce();
    chk("err_sticky", credit_err, 1);

    // Link drop while holding a token.
    q.push_back(8'h71); q.push_back(8'h72);
    step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    chk("held_valid", tx_valid, 1);
    step(0, 0, 0, 0);
    chk("drop_valid", tx_valid, 0);
    chk("drop_credit", credit, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("held_72", tx_data, 8'h72);

    // Asynchronous reset mid-HOLD clears outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_credit", credit, 0);
    chk("arst_err", credit_err, 0);
    chk("arst_ctrl", tx_ctrl, 0);
    chk("arst_data", tx_data, 0);
    chk("arst_r_en", r_en, 0);
    model_reset();
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ((q.size() < 64) && ($urandom_range(0, 2) == 0)) q.push_back(8'($urandom));
      step($urandom_range(0, 99) < 97, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_flow_ctrl.md
TX_FLOW_CTRL -- requirements
Module: tx_flow_ctrl

Interface
REQ-001 SHALL have parameter G_DATA_WIDTH_BITS, default 8, width of FIFO read data and tx_data.
REQ-002 SHALL have parameter G_ADDR_WIDTH_BITS, default 6, FIFO address width; fill_level is G_ADDR_WIDTH_BITS+1 bits.
REQ-003 SHALL have parameter G_CREDIT_MAX, default 56, credit ceiling (7 FCTs x 8 chars).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port link_up, input, 1, high while the DS link is in Run state.
REQ-007 SHALL have port fill_level, input, G_ADDR_WIDTH_BITS+1, upstream TX FIFO occupancy.
REQ-008 SHALL have port r_data, input, G_DATA_WIDTH_BITS, FIFO head word, valid combinationally whenever fill_level>0.
REQ-009 SHALL have port r_en, output, 1, one-cycle FIFO pop strobe.
REQ-010 SHALL have port fct_rcvd, input, 1, one-cycle pulse: peer granted 8 credits.
REQ-011 SHALL have port fct_send_req, input, 1, one-cycle pulse: local receiver freed 8 slots; queue one FCT.
REQ-012 SHALL have port tx_valid, output, 1, token present on tx_ctrl/tx_data.
REQ-013 SHALL have port tx_ready, input, 1, downstream encoder accepts token when tx_valid&tx_ready.
REQ-014 SHALL have port tx_ctrl, output, 1, 1 = FCT control token, 0 = data character.
REQ-015 SHALL have port tx_data, output, G_DATA_WIDTH_BITS, character data; all-zero when tx_ctrl=1.
REQ-016 SHALL have port credit, output, 6, current transmit credit count.
REQ-017 SHALL have port credit_err, output, 1, sticky credit-overflow flag.

Function
REQ-018 SHALL implement FSM states DISABLED, IDLE, HOLD; DISABLED whenever link_up=0, DISABLED->IDLE on first clk with link_up=1.
REQ-019 SHALL, in IDLE or in HOLD on the acceptance cycle, load the output register with the next token in the same cycle (zero-bubble, max one token per clk); HOLD if loaded, else IDLE.
REQ-020 SHALL give FCT priority: load an FCT token whenever fct_pending>0.
REQ-021 SHALL load a data token only when fct_pending=0, fill_level!=0 and credit!=0: tx_data<=r_data, tx_ctrl<=0, r_en=1 for exactly that cycle, credit decremented.
REQ-022 SHALL hold tx_valid, tx_ctrl, tx_data stable in HOLD until tx_valid&tx_ready.
REQ-023 SHALL never assert r_en outside a data-token load, nor more than once per loaded character.
REQ-024 SHALL keep a 3-bit fct_pending counter: +1 on fct_send_req, -1 on FCT load, both same cycle = unchanged; saturates at 7 with credit_err set on overflow.
REQ-025 SHALL update credit as credit + 8*fct_rcvd - data_load in one cycle; simultaneous grant and load = net +7.
REQ-026 SHALL saturate credit at G_CREDIT_MAX when the sum exceeds it and set credit_err (sticky until reset).
REQ-027 SHALL, when link_up falls (any state), in the next clk: tx_valid=0, credit=0, fct_pending=0, state DISABLED; a held data token is discarded (already popped).
REQ-028 SHALL ignore fct_rcvd and fct_send_req while DISABLED.
REQ-029 SHALL make tx_valid, tx_ctrl, tx_data, credit registered outputs; r_en combinational from the load decision.

Reset
REQ-030 SHALL, on rst_n=0, asynchronously force state DISABLED, tx_valid=0, tx_ctrl=0, tx_data=0, credit=0, fct_pending=0, credit_err=0, r_en=0.
REQ-031 SHALL resume operation on the first rising clk after rst_n deasserts, with link_up sampled normally.

Verification
REQ-032 SHALL cover: link_up=1, fill_level=3 (A1,B2,C3), credit 0, no fct_rcvd -> tx_valid stays 0, r_en never asserted.
REQ-033 SHALL cover: one fct_rcvd, fill 3, tx_ready=1 -> A1,B2,C3 on consecutive cycles, 3 r_en pulses, credit 8->5.
REQ-034 SHALL cover: 10 data queued, credit 8, tx_ready=1 -> exactly 8 characters sent, then tx_valid=0, credit=0, fill_level=2.
REQ-035 SHALL cover: fct_send_req while data pending, credit>0 -> FCT token (tx_ctrl=1, tx_data=0) sent before next data character.
REQ-036 SHALL cover: 8 fct_rcvd pulses from credit 0 -> credit saturates 56, credit_err=1 and stays 1 until rst_n.
REQ-037 SHALL cover: link_up dropped while tx_valid=1, tx_ready=0 -> next clk tx_valid=0, credit=0; rst_n pulse mid-HOLD -> all outputs zero immediately.
